// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard-controller enums and the per-stage
// load/flush control word.
package rv32i_types;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_HOLD     = 7'b00000_00;
  localparam stage_ctrl_t CTRL_RUN      = 7'b11111_00;
  localparam stage_ctrl_t CTRL_REDIRECT = 7'b11111_11;
  // Load-use bubble: freeze PC/IF-ID, insert a NOP into ID/EX, let older stages drain.
  localparam stage_ctrl_t CTRL_BUBBLE   = 7'b00111_01;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
  import rv32i_types::*;
#(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 32
);

  logic                   imem_read;
  logic                   imem_resp;
  logic                   dmem_req;
  logic                   dmem_resp;
  logic [REG_AW-1:0]      ifid_rs1;
  logic [REG_AW-1:0]      ifid_rs2;
  logic [REG_AW-1:0]      idex_rs1;
  logic [REG_AW-1:0]      idex_rs2;
  logic [REG_AW-1:0]      idex_rd;
  logic                   idex_wr;
  logic                   idex_is_load;
  logic [REG_AW-1:0]      exmem_rd;
  logic                   exmem_wr;
  logic [REG_AW-1:0]      memwb_rd;
  logic                   memwb_wr;
  logic                   redirect;

  logic                   load_pc;
  logic                   load_ifid;
  logic                   load_idex;
  logic                   load_exmem;
  logic                   load_memwb;
  logic                   flush_ifid;
  logic                   flush_idex;
  fwd_sel_t               fwd_a_sel;
  fwd_sel_t               fwd_b_sel;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp,
           ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_wr, idex_is_load,
           exmem_rd, exmem_wr, memwb_rd, memwb_wr, redirect,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel, stall_cycles
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp,
           ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_wr, idex_is_load,
           exmem_rd, exmem_wr, memwb_rd, memwb_wr, redirect,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_tracker.sv
// Per-port wait tracker: remembers a response that arrived while the pipeline
// was held, so it still counts once the other port catches up.
module mem_wait_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic resp_i,
  input  logic wait_i,
  input  logic advance_i,
  output logic ok_o
);

  logic done_q, done_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    done_d = done_q;
    if (advance_i) begin
      done_d = 1'b0;
    end else if (wait_i && resp_i) begin
      done_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign ok_o = ~req_i | resp_i | done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline: per-stage
// load and flush enables, independent I/D wait tracking, EX operand forwarding.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int REG_AW      = 5,
  parameter bit FWD_EN      = 1'b1,
  parameter int STALL_CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  hz_state_t              state_q, state_d;
  logic                   i_ok, d_ok, mem_stall;
  logic                   data_hazard;
  stage_ctrl_t            ctrl;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  function automatic logic rd_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] rs,
                                        input logic exm_wr, input logic [REG_AW-1:0] exm_rd,
                                        input logic mwb_wr, input logic [REG_AW-1:0] mwb_rd);
    if (!FWD_EN)                        return FWD_RF;
    if (rd_hit(exm_wr, exm_rd, rs))     return FWD_EXMEM;
    if (rd_hit(mwb_wr, mwb_rd, rs))     return FWD_MEMWB;
    return FWD_RF;
  endfunction

  mem_wait_tracker u_i_trk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (hz.imem_read),
    .resp_i    (hz.imem_resp),
    .wait_i    (state_q == HZ_MEM_WAIT),
    .advance_i (~mem_stall),
    .ok_o      (i_ok)
  );

  mem_wait_tracker u_d_trk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (hz.dmem_req),
    .resp_i    (hz.dmem_resp),
    .wait_i    (state_q == HZ_MEM_WAIT),
    .advance_i (~mem_stall),
    .ok_o      (d_ok)
  );

  assign mem_stall = ~(i_ok & d_ok);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:      if (mem_stall)  state_d = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (!mem_stall) state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Without forwarding, any in-flight writer to an ID source must retire first.
  always_comb begin
    data_hazard = 1'b0;
    if (FWD_EN) begin
      data_hazard = hz.idex_is_load &&
                    (rd_hit(hz.idex_wr, hz.idex_rd, hz.ifid_rs1) ||
                     rd_hit(hz.idex_wr, hz.idex_rd, hz.ifid_rs2));
    end else begin
      data_hazard = rd_hit(hz.idex_wr,  hz.idex_rd,  hz.ifid_rs1) ||
                    rd_hit(hz.idex_wr,  hz.idex_rd,  hz.ifid_rs2) ||
                    rd_hit(hz.exmem_wr, hz.exmem_rd, hz.ifid_rs1) ||
                    rd_hit(hz.exmem_wr, hz.exmem_rd, hz.ifid_rs2) ||
                    rd_hit(hz.memwb_wr, hz.memwb_rd, hz.ifid_rs1) ||
                    rd_hit(hz.memwb_wr, hz.memwb_rd, hz.ifid_rs2);
    end
  end

  // A redirect seen during a memory wait stays in EX and is acted on once the wait ends.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n || mem_stall) begin
      ctrl = CTRL_HOLD;
    end else if (hz.redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if (data_hazard) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign hz.load_pc    = ctrl.load_pc;
  assign hz.load_ifid  = ctrl.load_ifid;
  assign hz.load_idex  = ctrl.load_idex;
  assign hz.load_exmem = ctrl.load_exmem;
  assign hz.load_memwb = ctrl.load_memwb;
  assign hz.flush_ifid = ctrl.flush_ifid;
  assign hz.flush_idex = ctrl.flush_idex;

  assign hz.fwd_a_sel = rst_n ? fwd_pick(hz.idex_rs1, hz.exmem_wr, hz.exmem_rd,
                                         hz.memwb_wr, hz.memwb_rd) : FWD_RF;
  assign hz.fwd_b_sel = rst_n ? fwd_pick(hz.idex_rs2, hz.exmem_wr, hz.exmem_rd,
                                         hz.memwb_wr, hz.memwb_rd) : FWD_RF;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!ctrl.load_pc && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a forwarding instance (32-bit counter) and a no-forwarding
// instance (3-bit counter, exercises saturation) driven by the same stimulus.
module tb_pipeline_hazard_ctrl;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       imem_read, imem_resp, dmem_req, dmem_resp;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_wr, idex_is_load, exmem_wr, memwb_wr, redirect;

  localparam logic [6:0] HOLD  = 7'b00000_00;
  localparam logic [6:0] RUN   = 7'b11111_00;
  localparam logic [6:0] REDIR = 7'b11111_11;
  localparam logic [6:0] BUBL  = 7'b00111_01;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .STALL_CNT_W(32)) hz1 ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .STALL_CNT_W(3))  hz0 ();

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .STALL_CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hz(hz1.slave));
  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .STALL_CNT_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hz(hz0.slave));

  assign hz1.imem_read = imem_read;    assign hz0.imem_read = imem_read;
  assign hz1.imem_resp = imem_resp;    assign hz0.imem_resp = imem_resp;
  assign hz1.dmem_req  = dmem_req;     assign hz0.dmem_req  = dmem_req;
  assign hz1.dmem_resp = dmem_resp;    assign hz0.dmem_resp = dmem_resp;
  assign hz1.ifid_rs1  = ifid_rs1;     assign hz0.ifid_rs1  = ifid_rs1;
  assign hz1.ifid_rs2  = ifid_rs2;     assign hz0.ifid_rs2  = ifid_rs2;
  assign hz1.idex_rs1  = idex_rs1;     assign hz0.idex_rs1  = idex_rs1;
  assign hz1.idex_rs2  = idex_rs2;     assign hz0.idex_rs2  = idex_rs2;
  assign hz1.idex_rd   = idex_rd;      assign hz0.idex_rd   = idex_rd;
  assign hz1.idex_wr   = idex_wr;      assign hz0.idex_wr   = idex_wr;
  assign hz1.idex_is_load = idex_is_load; assign hz0.idex_is_load = idex_is_load;
  assign hz1.exmem_rd  = exmem_rd;     assign hz0.exmem_rd  = exmem_rd;
  assign hz1.exmem_wr  = exmem_wr;     assign hz0.exmem_wr  = exmem_wr;
  assign hz1.memwb_rd  = memwb_rd;     assign hz0.memwb_rd  = memwb_rd;
  assign hz1.memwb_wr  = memwb_wr;     assign hz0.memwb_wr  = memwb_wr;
  assign hz1.redirect  = redirect;     assign hz0.redirect  = redirect;

  wire [6:0] ctrl1 = {hz1.load_pc, hz1.load_ifid, hz1.load_idex, hz1.load_exmem,
                      hz1.load_memwb, hz1.flush_ifid, hz1.flush_idex};
  wire [6:0] ctrl0 = {hz0.load_pc, hz0.load_ifid, hz0.load_idex, hz0.load_exmem,
                      hz0.load_memwb, hz0.flush_ifid, hz0.flush_idex};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
    idex_wr = 0; idex_is_load = 0; exmem_rd = 0; exmem_wr = 0;
    memwb_rd = 0; memwb_wr = 0; redirect = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // 1: reset holds every enable low and forwarding at regfile.
    redirect = 1; exmem_rd = 3; exmem_wr = 1; idex_rs1 = 3;
    #2;
    check("rst_ctrl1", 32'(ctrl1), 32'(HOLD));
    check("rst_ctrl0", 32'(ctrl0), 32'(HOLD));
    check("rst_fwd_a", 32'(hz1.fwd_a_sel), 32'(FWD_RF));
    next_cycle();
    next_cycle();
    check("rst_stall_cnt", hz1.stall_cycles, 32'd0);
    rst_n = 1'b1;
    clear_inputs();
    #2;
    check("post_rst_ctrl", 32'(ctrl1), 32'(RUN));
    check("post_rst_cnt", hz1.stall_cycles, 32'd0);
    next_cycle();

    // 2: I response in cycle 2, D response in cycle 5.
    for (int c = 0; c <= 6; c++) begin
      imem_read = (c <= 5);
      dmem_req  = (c <= 5);
      imem_resp = (c == 2);
      dmem_resp = (c == 5);
      #2;
      check($sformatf("mw_ctrl1_c%0d", c), 32'(ctrl1), 32'((c >= 5) ? RUN : HOLD));
      check($sformatf("mw_ctrl0_c%0d", c), 32'(ctrl0), 32'((c >= 5) ? RUN : HOLD));
      check($sformatf("mw_idone_c%0d", c), 32'(u_dut1.u_i_trk.done_q),
            32'((c >= 3 && c <= 5) ? 1 : 0));
      if (c >= 5) check($sformatf("mw_cnt_c%0d", c), hz1.stall_cycles, 32'd5);
      next_cycle();
    end
    clear_inputs();

    // 3: lw x5 in EX, add x6,x5,x1 in ID.
    idex_is_load = 1; idex_wr = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs2 = 1;
    #2;
    check("lu_ctrl1", 32'(ctrl1), 32'(BUBL));
    check("lu_ctrl0", 32'(ctrl0), 32'(BUBL));
    next_cycle();
    check("lu_cnt", hz1.stall_cycles, 32'd6);
    idex_is_load = 0; idex_wr = 0; idex_rd = 0; exmem_rd = 5; exmem_wr = 1;
    #2;
    check("lu_bubble_ctrl1", 32'(ctrl1), 32'(RUN));
    check("lu_bubble_ctrl0", 32'(ctrl0), 32'(BUBL));
    next_cycle();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 5; idex_rs2 = 1;
    exmem_rd = 0; exmem_wr = 0; memwb_rd = 5; memwb_wr = 1;
    #2;
    check("lu_fwd_a1", 32'(hz1.fwd_a_sel), 32'(FWD_MEMWB));
    check("lu_fwd_b1", 32'(hz1.fwd_b_sel), 32'(FWD_RF));
    check("lu_fwd_a0", 32'(hz0.fwd_a_sel), 32'(FWD_RF));
    check("lu_add_ctrl1", 32'(ctrl1), 32'(RUN));
    next_cycle();
    clear_inputs();

    // 4: forwarding priority and x0.
    exmem_rd = 3; exmem_wr = 1; memwb_rd = 3; memwb_wr = 1; idex_rs1 = 3; idex_rs2 = 3;
    #2;
    check("fw_prio_a", 32'(hz1.fwd_a_sel), 32'(FWD_EXMEM));
    check("fw_prio_b", 32'(hz1.fwd_b_sel), 32'(FWD_EXMEM));
    next_cycle();
    exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
    #2;
    check("fw_x0_a", 32'(hz1.fwd_a_sel), 32'(FWD_RF));
    next_cycle();
    exmem_rd = 3; exmem_wr = 0; memwb_rd = 4; memwb_wr = 1; idex_rs1 = 3; idex_rs2 = 4;
    #2;
    check("fw_nowr_a", 32'(hz1.fwd_a_sel), 32'(FWD_RF));
    check("fw_wb_b", 32'(hz1.fwd_b_sel), 32'(FWD_MEMWB));
    next_cycle();
    clear_inputs();

    // 5: redirect beats load-use; then the same under a D-port wait.
    redirect = 1; idex_is_load = 1; idex_wr = 1; idex_rd = 5; ifid_rs1 = 5;
    #2;
    check("rd_ctrl1", 32'(ctrl1), 32'(REDIR));
    check("rd_ctrl0", 32'(ctrl0), 32'(REDIR));
    next_cycle();
    dmem_req = 1;
    for (int c = 0; c <= 2; c++) begin
      dmem_resp = (c == 2);
      #2;
      check($sformatf("rdw_ctrl1_c%0d", c), 32'(ctrl1), 32'((c == 2) ? REDIR : HOLD));
      next_cycle();
    end
    clear_inputs();
    #2;
    check("rdw_cnt", hz1.stall_cycles, 32'd8);
    check("rdw_ddone", 32'(u_dut1.u_d_trk.done_q), 32'd0);
    next_cycle();

    // 6: no forwarding: writer to x7 walks EX -> MEM -> WB while ID reads x7.
    ifid_rs1 = 7; idex_rd = 7; idex_wr = 1;
    #2;
    check("nf_ex_ctrl0", 32'(ctrl0), 32'(BUBL));
    check("nf_ex_ctrl1", 32'(ctrl1), 32'(RUN));
    next_cycle();
    idex_rd = 0; idex_wr = 0; exmem_rd = 7; exmem_wr = 1; idex_rs1 = 7;
    #2;
    check("nf_mem_ctrl0", 32'(ctrl0), 32'(BUBL));
    check("nf_mem_fwd0", 32'(hz0.fwd_a_sel), 32'(FWD_RF));
    next_cycle();
    exmem_rd = 0; exmem_wr = 0; memwb_rd = 7; memwb_wr = 1;
    #2;
    check("nf_wb_ctrl0", 32'(ctrl0), 32'(BUBL));
    check("nf_wb_fwd0", 32'(hz0.fwd_a_sel), 32'(FWD_RF));
    check("nf_wb_fwd1", 32'(hz1.fwd_a_sel), 32'(FWD_MEMWB));
    next_cycle();
    memwb_rd = 0; memwb_wr = 0;
    #2;
    check("nf_done_ctrl0", 32'(ctrl0), 32'(RUN));
    next_cycle();
    clear_inputs();
    #2;
    check("sat_cnt0", 32'(hz0.stall_cycles), 32'd7);
    check("final_cnt1", hz1.stall_cycles, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
